md_unit: RTL and testbench
==========================

# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, placed in the EX stage beside the ALU. It runs signed/unsigned multiply and divide on operands latched at start and holds `busy` for a configurable latency. It then commits the result to HI/LO and supports direct HI/LO writes (mthi/mtlo). `md_stall` feeds the hazard unit so that mult/div/mfhi/mflo/mthi/mtlo in D stall while an operation is pending.

## Interface
- WIDTH, 32, operand and HI/LO width (≥2)
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the next rising clk edge)
- start  in  1  launch operation `op` on `a`,`b` this cycle
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  operand rs (forwarded value)
- b  in  WIDTH  operand rt (forwarded value)
- hi_we  in  1  mthi: write `wdata` to HI
- lo_we  in  1  mtlo: write `wdata` to LO
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in flight (registered)
- md_stall  out  1  combinational `busy | start`
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN. Count register `cnt` and a result buffer (2·WIDTH bits) are internal.
- IDLE + start:
  - Latch the op result into the buffer. Computation may be combinational at start or iterative; only the commit timing is visible.
  - Set `cnt` = MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN:
  - `cnt` decrements each cycle.
  - On the cycle with `cnt`==1, commit HI/LO at that edge and return to IDLE.
- mult/multu: {HI,LO} = full 2·WIDTH product, signed or unsigned per op.
- div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = a.
  - Signed overflow (a = most-negative, b = −1): LO = a, HI = 0.
- Direct writes:
  - hi_we/lo_we in IDLE without start write `wdata` at the edge. Both asserted together write both registers.
  - In IDLE with start in the same cycle, start wins and the write is dropped.
- In RUN, start, hi_we and lo_we are ignored. The hazard unit must not issue them; the unit does not queue them.
- `hi`/`lo` hold their old values throughout RUN and change only at commit.

## Timing
- Reset (reset==0 at an edge): state IDLE, busy=0, cnt=0, hi=0, lo=0, buffer discarded.
  - Reset mid-RUN aborts the operation with no late commit.
  - Reset takes priority over start and hi_we/lo_we.
- start sampled at edge E0:
  - busy=1 in the cycles after E0 … E(L−1), where L = MULT_CYCLES or DIV_CYCLES.
  - At edge E(L), hi/lo update and busy=0, so the new values are readable in the cycle after E(L).
- With L=1: busy is high for exactly one cycle.
- Back-to-back: start in the first cycle with busy=0 is accepted, giving zero idle bubble.
- mthi/mtlo latency: 1 edge.
- md_stall is high in the start cycle and for all busy cycles.
- Operands `a`/`b` are only sampled at start. Changes during RUN have no effect.

## Test plan
(WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
- Signed mult: start, op=00, a=0xFFFFFFFE, b=3 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Unsigned: op=01, same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Division: op=10, a=0xFFFFFFF9, b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. op=11, a=7, b=2 → lo=3, hi=1.
- Division corner cases:
  - op=10, a=5, b=0 → lo=0xFFFFFFFF, hi=5.
  - op=10, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Ignored inputs during RUN:
  - During a mult, pulse start (op=10) and hi_we (wdata=0x1234).
  - Required: hi/lo unchanged until commit, the commit holds the mult result, and busy falls after exactly 5 cycles.
  - Then, idle: hi_we=1, lo_we=1, wdata=0xABCD → hi=lo=0xABCD next cycle.
- Priority and reset:
  - Idle with start and lo_we in the same cycle → the write is dropped.
  - reset=0 at the 3rd busy cycle of a div → next cycle busy=0, hi=lo=0, and no commit afterwards.
- Back-to-back: a mult followed by start on the first non-busy cycle → second result commits 5 cycles later, and md_stall stays continuous across the boundary.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed when the operation starts and committed to HI/LO after a fixed latency.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   rbuf;

  logic                 sgn, na, nb;
  logic [2*WIDTH-1:0]   ea, eb, prod, res;
  logic [WIDTH-1:0]     ua, ub, ubs, uq, ur, q, r;

  // Signed and unsigned products share one multiplier over sign- or zero-extended operands.
  // Division works on magnitudes and then restores the signs. Overflow (min / -1) needs no
  // special case, because negating the most-negative value gives that value back.
  always_comb begin
    sgn  = ~op[0];
    ea   = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    eb   = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    prod = ea * eb;
    na   = sgn & a[WIDTH-1];
    nb   = sgn & b[WIDTH-1];
    ua   = na ? -a : a;
    ub   = nb ? -b : b;
    ubs  = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
    uq   = ua / ubs;
    ur   = ua % ubs;
    q    = (na ^ nb) ? -uq : uq;
    r    = na ? -ur : ur;
    if (op[1]) res = (b == '0) ? {a, {WIDTH{1'b1}}} : {r, q};
    else       res = prod;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      rbuf  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rbuf  <= res;
            cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            {hi, lo} <= rbuf;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md_stall = busy | start;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: queues the expected {hi,lo} and latency when an op launches,
// then checks them at commit. HI/LO must hold and md_stall must stay high while busy.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, md_stall;
  logic [W-1:0] hi, lo;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_fail = 0;
  logic [63:0]   expq[$];
  int            latq[$];
  logic [W-1:0]  mhi = '0, mlo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy, qq, rr;
    logic [63:0] ux, uy;
    case (o)
      2'b00: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      2'b01: begin ux = {32'h0, x}; uy = {32'h0, y}; return ux * uy; end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, x};
        sx = x; sy = y; qq = sx / sy; rr = sx % sy;
        return {rr, qq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive start for one cycle; the write enables go along with it to exercise start priority.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic hw, input logic lw);
    start = 1'b1; op = o; a = x; b = y; hi_we = hw; lo_we = lw; wdata = 32'h5555AAAA;
    #1;
    check("stall_at_start", md_stall, 1'b1);
    expq.push_back(model(o, x, y));
    latq.push_back(o[1] ? DC : MC);
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Count busy cycles, scramble operands, optionally poke ignored inputs, then compare the commit.
  task automatic finish_op(input int poke);
    int n = 0;
    int lat;
    logic [63:0] e;
    while (busy && n < 50) begin
      check("stall_busy", md_stall, 1'b1);
      check("hold_hi", hi, mhi);
      check("hold_lo", lo, mlo);
      n++;
      a = $urandom; b = $urandom;
      if (n == poke) begin
        start = 1'b1; op = 2'b10; hi_we = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      step();
    end
    start = 1'b0; hi_we = 1'b0;
    if (expq.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = expq.pop_front();
      lat = latq.pop_front();
      check("busy_cycles", n, lat);
      check("busy_fall", busy, 1'b0);
      check("commit_hi", hi, e[63:32]);
      check("commit_lo", lo, e[31:0]);
      mhi = e[63:32]; mlo = e[31:0];
    end
  endtask

  initial begin
    step(); step();
    check("rst_busy", busy, 1'b0);
    check("rst_stall", md_stall, 1'b0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b1;
    step();

    launch(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0); finish_op(0);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFFA);
    launch(2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0); finish_op(0);
    check("multu_hi_const", hi, 32'h00000002);
    launch(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0); finish_op(0);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    check("div_hi_const", hi, 32'hFFFFFFFF);
    launch(2'b11, 32'd7, 32'd2, 1'b0, 1'b0); finish_op(0);
    launch(2'b10, 32'd5, 32'd0, 1'b0, 1'b0); finish_op(0);
    check("divz_hi_const", hi, 32'd5);
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0); finish_op(0);
    check("ovf_lo_const", lo, 32'h80000000);

    // ignored start/mthi during a multiply
    launch(2'b00, 32'd1234567, 32'hFFFF0001, 1'b0, 1'b0); finish_op(2);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    mhi = 32'hABCD; mlo = 32'hABCD;
    check("mthi", hi, mhi);
    check("mtlo", lo, mlo);
    hi_we = 1'b1; wdata = 32'h77;
    step();
    hi_we = 1'b0; mhi = 32'h77;
    check("mthi_only_hi", hi, mhi);
    check("mthi_only_lo", lo, mlo);

    // start beats lo_we; the hold checks during RUN catch a leaked write
    launch(2'b11, 32'd100, 32'd7, 1'b0, 1'b1); finish_op(0);

    // back-to-back with zero bubble, then a few random ops
    launch(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0); finish_op(0);
    launch(2'b01, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0); finish_op(0);
    for (int i = 0; i < 6; i++) begin
      launch(2'($urandom_range(3)), $urandom, (i == 5) ? 32'd0 : $urandom, 1'b0, 1'b0);
      finish_op(0);
    end

    // reset during the 3rd busy cycle of a divide
    launch(2'b10, 32'd1000, 32'd3, 1'b0, 1'b0);
    step(); step();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    void'(expq.pop_front()); void'(latq.pop_front());
    mhi = '0; mlo = '0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    for (int i = 0; i < DC + 2; i++) step();
    check("no_late_commit_hi", hi, 0);
    check("no_late_commit_lo", lo, 0);
    check("no_late_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
